// File: rtl/csa_pkg.sv
// Shared types and parameter checks for the carry-save accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic bit csa_params_ok(input int width, input int num_ops, input int acc_width);
        return (acc_width >= width) && (num_ops >= 1);
    endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: three W-bit words in, redundant (sum, carry) pair out.
module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: carry-save reduction per beat, a single carry-propagate
// add per packet, result presented on a valid/ready output.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_OPS   = 3,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0]     out_beats
);

    if (!csa_params_ok(WIDTH, NUM_OPS, ACC_WIDTH)) begin : g_param_check
        $error("csa_accumulator: need ACC_WIDTH >= WIDTH and NUM_OPS >= 1");
    end

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [ACC_WIDTH-1:0]   carry_q, carry_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]   out_beats_q, out_beats_d;

    // Entry 0 is the registered state; entry k+1 is the output of row k.
    logic [NUM_OPS:0][ACC_WIDTH-1:0] row_sum;
    logic [NUM_OPS:0][ACC_WIDTH-1:0] row_carry;

    assign row_sum[0]   = sum_q;
    assign row_carry[0] = carry_q;

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_rows
        logic [ACC_WIDTH-1:0] carry_shl;
        logic [ACC_WIDTH-1:0] operand;

        // Carry weight doubles; the shift discards the MSB, giving modulo arithmetic.
        assign carry_shl = row_carry[gi] << 1;
        assign operand   = ACC_WIDTH'(in_data[gi*WIDTH +: WIDTH]);

        csa_row #(
            .W(ACC_WIDTH)
        ) u_row (
            .a    (row_sum[gi]),
            .b    (carry_shl),
            .c    (operand),
            .sum  (row_sum[gi+1]),
            .carry(row_carry[gi+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    sum_d   = row_sum[NUM_OPS];
                    carry_d = row_carry[NUM_OPS];
                    if (count_q != {CNT_WIDTH{1'b1}}) begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_data_d  = sum_q + (carry_q << 1);
                out_beats_d = count_q;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    sum_d   = '0;
                    carry_d = '0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            carry_q     <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

    // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: default configuration plus a NUM_OPS=1, ACC_WIDTH=8 instance.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  out_beats;

    logic        d1_in_valid = 1'b0;
    logic        d1_in_ready;
    logic [7:0]  d1_in_data = '0;
    logic        d1_in_last = 1'b0;
    logic        d1_out_valid;
    logic        d1_out_ready = 1'b0;
    logic [7:0]  d1_out_data;
    logic [7:0]  d1_out_beats;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_accumulator #(
        .WIDTH(8), .NUM_OPS(3), .ACC_WIDTH(16), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
    );

    csa_accumulator #(
        .WIDTH(8), .NUM_OPS(1), .ACC_WIDTH(8), .CNT_WIDTH(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data), .in_last(d1_in_last),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data), .out_beats(d1_out_beats)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Presents one beat from the falling edge; it is accepted on the following rising edge.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic last);
        @(negedge clk);
        check("beat_in_ready", 32'(in_ready), 32'd1);
        in_data  = {c, b, a};
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the falling edge right after the last beat was accepted.
    task automatic take_result(input string tag, input logic [15:0] exp_data, input logic [7:0] exp_beats,
                               input int hold);
        check({tag, "_resolve_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_resolve_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 8 && !out_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_beats"}, 32'(out_beats), 32'(exp_beats));
        $display("pkt %s data=%0d beats=%0d", tag, out_data, out_beats);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp_data));
            check({tag, "_hold_beats"}, 32'(out_beats), 32'(exp_beats));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_cleared_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_cleared_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_beats", 32'(out_beats), 32'd0);
        rst_n = 1'b1;

        beat(8'd10, 8'd20, 8'd30, 1'b1);
        idle();
        take_result("single", 16'd60, 8'd1, 0);

        beat(8'd255, 8'd255, 8'd255, 1'b0);
        beat(8'd255, 8'd255, 8'd255, 1'b1);
        idle();
        take_result("two", 16'd1530, 8'd2, 0);

        for (int i = 1; i <= 86; i++) beat(8'd255, 8'd255, 8'd255, i == 86);
        idle();
        take_result("wrap86", 16'd254, 8'd86, 0);

        beat(8'd5, 8'd6, 8'd7, 1'b1);
        idle();
        take_result("hold", 16'd18, 8'd1, 5);
        beat(8'd1, 8'd2, 8'd3, 1'b1);
        idle();
        take_result("after_hold", 16'd6, 8'd1, 0);

        beat(8'd100, 8'd100, 8'd100, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_beats", 32'(out_beats), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'd7, 8'd8, 8'd9, 1'b1);
        idle();
        take_result("after_rst", 16'd24, 8'd1, 0);

        @(negedge clk);
        d1_in_data  = 8'd200;
        d1_in_last  = 1'b0;
        d1_in_valid = 1'b1;
        @(negedge clk);
        d1_in_data  = 8'd100;
        d1_in_last  = 1'b1;
        @(negedge clk);
        d1_in_valid = 1'b0;
        d1_in_last  = 1'b0;
        for (int i = 0; i < 8 && !d1_out_valid; i++) @(negedge clk);
        check("n1_valid", 32'(d1_out_valid), 32'd1);
        check("n1_data", 32'(d1_out_data), 32'd44);
        check("n1_beats", 32'(d1_out_beats), 32'd2);
        $display("pkt n1 data=%0d beats=%0d", d1_out_data, d1_out_beats);
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
        check("n1_cleared_valid", 32'(d1_out_valid), 32'd0);
        check("n1_cleared_ready", 32'(d1_in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
